// File: rtl/program_counter_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | program_counter_unit: EDiC program counter with a hardware return stack. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module program_counter_unit #(
  parameter int               WIDTH        = 8,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic [WIDTH-1:0]                   i_bus,
  input  logic                               i_ctrlLoadPC,
  input  logic                               i_ctrlIncrPC,
  input  logic                               i_ctrlPCNOe,
  input  logic                               i_ctrlCall,
  input  logic                               i_ctrlRet,
  output logic [WIDTH-1:0]                   o_pc,
  output logic [WIDTH-1:0]                   o_bus,
  output logic                               o_busDrive,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_stackDepth,
  output logic                               o_stackOverflow,
  output logic                               o_stackUnderflow
);

  localparam int                 DEPTH_W    = $clog2(STACK_DEPTH + 1);
  localparam int                 IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [WIDTH-1:0]   stack_d [STACK_DEPTH];
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  // The top entry sits one below the push slot; modular wrap covers the full case.
  assign push_idx = depth_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (i_reset) begin
      pc_d    = RESET_VECTOR;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (i_ctrlRet) begin
      if (depth_q != '0) begin
        pc_d    = stack_q[pop_idx];
        depth_d = depth_q - DEPTH_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (i_ctrlCall) begin
      if (depth_q < FULL_DEPTH) begin
        stack_d[push_idx] = pc_q;
        depth_d           = depth_q + DEPTH_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
      pc_d = i_bus;
    end else if (i_ctrlLoadPC) begin
      pc_d = i_bus;
    end else if (i_ctrlIncrPC) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    pc_q    <= pc_d;
    depth_q <= depth_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
    stack_q <= stack_d;
  end

  // Bus path is purely combinational so the PC is visible in the enabling cycle.
  assign o_busDrive       = ~i_ctrlPCNOe;
  assign o_bus            = o_busDrive ? pc_q : '0;
  assign o_pc             = pc_q;
  assign o_stackDepth     = depth_q;
  assign o_stackOverflow  = ovf_q;
  assign o_stackUnderflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_program_counter_unit.sv
`default_nettype none
// Bench for program_counter_unit: queue-based reference model plus directed vectors.
module tb_program_counter_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic       ld = 1'b0, inc = 1'b0, pcn = 1'b1, cl = 1'b0, rt = 1'b0;
  logic [7:0] pc, bus_out;
  logic       drive, ovf, unf;
  logic [2:0] depth;

  int errors = 0;
  int checks = 0;

  int       m_pc;
  int       m_stack[$];
  bit       m_ovf, m_unf;
  bit       chk_en = 1'b0;

  program_counter_unit #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .i_clk(clk), .i_reset(rst), .i_bus(bus_in),
    .i_ctrlLoadPC(ld), .i_ctrlIncrPC(inc), .i_ctrlPCNOe(pcn),
    .i_ctrlCall(cl), .i_ctrlRet(rt),
    .o_pc(pc), .o_bus(bus_out), .o_busDrive(drive),
    .o_stackDepth(depth), .o_stackOverflow(ovf), .o_stackUnderflow(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every cycle after the first reset, all outputs must match the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("pc",       {24'd0, pc},      m_pc);
      chk("depth",    {29'd0, depth},   m_stack.size());
      chk("overflow", {31'd0, ovf},     {31'd0, m_ovf});
      chk("underflow",{31'd0, unf},     {31'd0, m_unf});
      chk("busDrive", {31'd0, drive},   {31'd0, ~pcn});
      chk("bus",      {24'd0, bus_out}, pcn ? 0 : m_pc);
    end
  end

  // One cycle: drive at negedge, check the zero-latency bus, model the edge.
  task automatic step(input bit r, input bit l, input bit i, input bit c,
                      input bit t, input logic [7:0] b, input bit p);
    @(negedge clk);
    rst = r; ld = l; inc = i; cl = c; rt = t; bus_in = b; pcn = p;
    #1;
    if (chk_en) begin
      chk("bus_comb",   {24'd0, bus_out}, p ? 0 : m_pc);
      chk("drive_comb", {31'd0, drive},   {31'd0, ~p});
    end
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (t) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_unf = 1;
    end else if (c) begin
      if (m_stack.size() < 4) m_stack.push_back(m_pc);
      else m_ovf = 1;
      m_pc = b;
    end else if (l) begin
      m_pc = b;
    end else if (i) begin
      m_pc = (m_pc + 1) % 256;
    end
    if (r) chk_en = 1'b1;
    #2;
  endtask

  task automatic idle();          step(0,0,0,0,0,8'h00,1); endtask
  task automatic incr();          step(0,0,1,0,0,8'h00,1); endtask
  task automatic load(input logic [7:0] b); step(0,1,0,0,0,b,1); endtask
  task automatic call(input logic [7:0] b); step(0,0,0,1,0,b,1); endtask
  task automatic ret();           step(0,0,0,0,1,8'h00,1); endtask
  task automatic reset();         step(1,0,0,0,0,8'h00,1); endtask

  initial begin
    reset(); reset();
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_depth", {29'd0, depth}, 0);

    // Incrementing from reset, then holding
    incr(); chk("inc1", {24'd0, pc}, 32'h01);
    incr(); chk("inc2", {24'd0, pc}, 32'h02);
    incr(); chk("inc3", {24'd0, pc}, 32'h03);
    idle(); idle(); chk("hold", {24'd0, pc}, 32'h03);

    // Wrap at the top of the address space
    load(8'hFE);
    incr(); chk("to_ff", {24'd0, pc}, 32'hFF);
    incr(); chk("wrap", {24'd0, pc}, 32'h00);
    chk("wrap_flags", {30'd0, ovf, unf}, 0);

    // Load beats increment
    step(0,1,1,0,0,8'h40,1); chk("load_incr", {24'd0, pc}, 32'h40);

    // Single call/return and underflow
    load(8'h10);
    call(8'h80); chk("call_pc", {24'd0, pc}, 32'h80); chk("call_depth", {29'd0, depth}, 1);
    ret();       chk("ret_pc", {24'd0, pc}, 32'h10);  chk("ret_depth", {29'd0, depth}, 0);
    ret();       chk("unf_pc", {24'd0, pc}, 32'h10);  chk("unf_flag", {31'd0, unf}, 1);
    idle();      chk("unf_sticky", {31'd0, unf}, 1);

    // Overflow on the fifth nested call, then LIFO unwind
    reset();
    for (int k = 1; k <= 5; k++) call(8'(k));
    chk("ovf_depth", {29'd0, depth}, 4);
    chk("ovf_flag", {31'd0, ovf}, 1);
    chk("ovf_pc", {24'd0, pc}, 32'h05);
    ret(); chk("lifo3", {24'd0, pc}, 32'h03);
    ret(); chk("lifo2", {24'd0, pc}, 32'h02);
    ret(); chk("lifo1", {24'd0, pc}, 32'h01);
    ret(); chk("lifo0", {24'd0, pc}, 32'h00);
    chk("ovf_sticky", {31'd0, ovf}, 1);

    // Simultaneous call and ret: ret wins
    reset(); load(8'h33); call(8'h77);
    step(0,0,0,1,1,8'h99,1); chk("callret_pc", {24'd0, pc}, 32'h33);
    chk("callret_depth", {29'd0, depth}, 0);

    // Bus drive, including while loading and during reset
    load(8'h2A);
    step(0,0,0,0,0,8'h00,0); chk("bus_on", {24'd0, bus_out}, 32'h2A);
    step(0,1,0,0,0,8'h55,0); chk("bus_after_load", {24'd0, bus_out}, 32'h55);
    step(0,0,0,0,0,8'h00,1); chk("bus_off", {24'd0, bus_out}, 32'h00);
    step(1,0,0,0,0,8'h00,0); chk("bus_in_reset", {24'd0, bus_out}, 32'h00);
    chk("drive_in_reset", {31'd0, drive}, 1);

    // Reset discards a concurrent call
    load(8'h12); call(8'h20);
    step(1,0,0,1,0,8'h60,1); chk("rst_call_pc", {24'd0, pc}, 32'h00);
    chk("rst_call_depth", {29'd0, depth}, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
